// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - streaming-loadable instruction memory with registered PC fetch
module instr_mem_loadable #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'b001001_000_000_0110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_done,
    output logic              prog_ready,
    output logic [ADDR_W:0]   prog_count,
    output logic              loaded,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_fault
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_WORD};

    logic              wr_en;
    logic              in_range;
    logic [ADDR_W:0]   count_inc;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign prog_ready = (state == S_LOAD);
    assign loaded     = (state == S_RUN);

    // prog_start wins over a concurrent word; the count guard keeps writes inside DEPTH
    assign wr_en     = (state == S_LOAD) && !rst && !prog_start && prog_valid &&
                       (prog_count < DEPTH_C);
    assign count_inc = prog_count + (ADDR_W + 1)'(1);
    assign in_range  = ({1'b0, pc} < DEPTH_C);
    assign wr_idx    = prog_count[IDX_W-1:0];
    assign rd_idx    = pc[IDX_W-1:0];

    // Contents deliberately survive rst so a partial load is still visible afterwards
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            prog_count  <= '0;
            instr       <= FILL_WORD;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    instr_valid <= 1'b0;
                    if (prog_start) begin
                        prog_count <= '0;
                    end else begin
                        if (wr_en) begin
                            prog_count <= count_inc;
                            if (count_inc == DEPTH_C) begin
                                state <= S_RUN;
                            end
                        end
                        if (prog_done) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (prog_start) begin
                        state       <= S_LOAD;
                        prog_count  <= '0;
                        instr_valid <= 1'b0;
                    end else if (stall) begin
                        instr       <= instr;
                        instr_valid <= instr_valid;
                        addr_fault  <= addr_fault;
                    end else if (fetch_en) begin
                        instr_valid <= 1'b1;
                        if (in_range) begin
                            instr      <= mem[rd_idx];
                            addr_fault <= 1'b0;
                        end else begin
                            instr      <= FILL_WORD;
                            addr_fault <= 1'b1;
                        end
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
